// File: rtl/game_layer_mixer.sv
// game_layer_mixer
//
// Two-stage pipelined priority mixer for the video path, plus the end-of-game
// overlay timer. The lowest-indexed layer that is both opaque (layer_en_i) and
// unmasked (layer_mask_i) wins. While the overlay FSM is active, the win/lose
// colour (LSB XORed with a noise bit) replaces the mixed pixel. hit_o and
// hit_layer_o keep tracking the layer data during the overlay.
//
// Optional feature: define GAME_LAYER_MIXER_BG_EN to output bg_rgb_i for
// empty pixels. Without it, bg_rgb_i is ignored and empty pixels are all-zero.
//
// Ports:
//   clk                pixel clock
//   rst                asynchronous, active-high reset
//   layer_en_i         per-layer opaque flag, bit i = layer i
//   layer_rgb_i        packed colours, layer i at [i*RGB_W +: RGB_W]
//   layer_mask_i       runtime layer enable
//   bg_rgb_i           background colour (only used with GAME_LAYER_MIXER_BG_EN)
//   overlay_start_i    single-cycle pulse that starts the overlay
//   game_won_i         picks the win or lose colour on the start cycle
//   random_i           noise bit XORed into the overlay LSB
//   rgb_o              mixed pixel (2-cycle latency)
//   hit_o              some unmasked layer was opaque
//   hit_layer_o        winning layer index, 0 when hit_o is 0
//   overlay_active_o   overlay FSM is in the overlay state
module game_layer_mixer #(
    parameter int unsigned N_LAYERS       = 12,
    parameter int unsigned RGB_W          = 3,
    parameter int unsigned OVERLAY_CYCLES = 1024,
    parameter logic [RGB_W-1:0] WIN_RGB   = 3'b100,
    parameter logic [RGB_W-1:0] LOSE_RGB  = 3'b110
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_LAYERS-1:0]           layer_en_i,
    input  logic [N_LAYERS*RGB_W-1:0]     layer_rgb_i,
    input  logic [N_LAYERS-1:0]           layer_mask_i,
    input  logic [RGB_W-1:0]              bg_rgb_i,
    input  logic                          overlay_start_i,
    input  logic                          game_won_i,
    input  logic                          random_i,
    output logic [RGB_W-1:0]              rgb_o,
    output logic                          hit_o,
    output logic [$clog2(N_LAYERS)-1:0]   hit_layer_o,
    output logic                          overlay_active_o
);

    localparam int unsigned IdxW = $clog2(N_LAYERS);
    localparam int unsigned CntW = $clog2(OVERLAY_CYCLES + 1);

    typedef enum logic {StIdle, StOverlay} state_e;

    // Priority encoder: iterate downward so the lowest set index wins.
    logic [N_LAYERS-1:0] eff;
    logic [IdxW-1:0]     sel_idx;
    logic                sel_hit;
    logic [RGB_W-1:0]    sel_rgb;

    always_comb begin
        eff     = layer_en_i & layer_mask_i;
        sel_idx = '0;
        sel_hit = 1'b0;
        sel_rgb = '0;
        for (int i = int'(N_LAYERS) - 1; i >= 0; i--) begin
            if (eff[i]) begin
                sel_idx = IdxW'(i);
                sel_hit = 1'b1;
                sel_rgb = layer_rgb_i[i*RGB_W +: RGB_W];
            end
        end
    end

    // Stage 1
    logic [IdxW-1:0]  s1_idx_q;
    logic             s1_hit_q;
    logic [RGB_W-1:0] s1_rgb_q;
    logic             s1_rnd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_idx_q <= '0;
            s1_hit_q <= 1'b0;
            s1_rgb_q <= '0;
            s1_rnd_q <= 1'b0;
        end else begin
            s1_idx_q <= sel_idx;
            s1_hit_q <= sel_hit;
            s1_rgb_q <= sel_rgb;
            s1_rnd_q <= random_i;
        end
    end

    // Background travels through stage 1 so it stays aligned with the layers.
    logic [RGB_W-1:0] bg_s1;

`ifdef GAME_LAYER_MIXER_BG_EN
    logic [RGB_W-1:0] s1_bg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_bg_q <= '0;
        end else begin
            s1_bg_q <= bg_rgb_i;
        end
    end

    assign bg_s1 = s1_bg_q;
`else
    logic unused_bg;
    assign unused_bg = ^bg_rgb_i;
    assign bg_s1     = '0;
`endif

    // Overlay FSM. A start pulse in StOverlay is ignored entirely.
    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [RGB_W-1:0] ovl_rgb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ovl_rgb_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (overlay_start_i) begin
                        state_q   <= StOverlay;
                        cnt_q     <= CntW'(OVERLAY_CYCLES - 1);
                        ovl_rgb_q <= game_won_i ? WIN_RGB : LOSE_RGB;
                    end
                end
                StOverlay: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Stage 2
    logic [RGB_W-1:0] rgb_d, rgb_q;
    logic             hit_q;
    logic [IdxW-1:0]  hit_layer_q;

    always_comb begin
        rgb_d = s1_hit_q ? s1_rgb_q : bg_s1;
        if (state_q == StOverlay) begin
            rgb_d = ovl_rgb_q ^ RGB_W'(s1_rnd_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q       <= '0;
            hit_q       <= 1'b0;
            hit_layer_q <= '0;
        end else begin
            rgb_q       <= rgb_d;
            hit_q       <= s1_hit_q;
            hit_layer_q <= s1_idx_q;
        end
    end

    assign rgb_o            = rgb_q;
    assign hit_o            = hit_q;
    assign hit_layer_o      = hit_layer_q;
    assign overlay_active_o = (state_q == StOverlay);

endmodule

// File: doc/game_layer_mixer.md
# game_layer_mixer

Parametrised, pipelined priority mixer for the game's video path. It combines N_LAYERS sprite layers into one RGB pixel: the lowest-indexed enabled layer wins. The block also owns the end-of-game overlay timer, so it sits between the sprite instances and the display controller. It replaces the fixed twelve-input mixer and adds a per-layer runtime mask, a reported winning-layer index, and a self-timed win/lose overlay.

## Interface
Parameters:
- N_LAYERS, 12, number of sprite layers; index 0 = highest priority; legal range 2..32
- RGB_W, 3, pixel width
- OVERLAY_CYCLES, 1024, overlay duration in clk cycles; legal range ≥1
- WIN_RGB, 3'b100, overlay colour when won (RGB_W bits)
- LOSE_RGB, 3'b110, overlay colour when lost (RGB_W bits)

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- layer_en  in  N_LAYERS  per-layer pixel-opaque flag, bit i = layer i
- layer_rgb  in  N_LAYERS*RGB_W  packed colours, layer i at [i*RGB_W +: RGB_W]
- layer_mask  in  N_LAYERS  runtime enable; 0 disables a layer regardless of layer_en
- bg_rgb  in  RGB_W  background colour (used only with GAME_LAYER_MIXER_BG_EN)
- overlay_start  in  1  single-cycle pulse that starts the end-of-game overlay
- game_won  in  1  sampled on the overlay_start cycle
- random  in  1  noise bit XORed into the overlay LSB
- rgb  out  RGB_W  mixed pixel, registered
- hit  out  1  some unmasked layer was opaque for this pixel
- hit_layer  out  $clog2(N_LAYERS)  index of the winning layer; 0 when hit=0
- overlay_active  out  1  overlay FSM is in state OVERLAY

## Operation
- Effective enable per layer: eff[i] = layer_en[i] & layer_mask[i].
- Stage 1 (registered):
  - priority-encode eff to the lowest set index, giving s1_idx and s1_hit;
  - register the selected layer colour into s1_rgb.
- Stage 2 (registered):
  - OVERLAY state: rgb = ovl_rgb ^ {{RGB_W-1{1'b0}}, random_s1}; hit and hit_layer still reflect layer data.
  - Otherwise: rgb = s1_hit ? s1_rgb : background, where background is bg_rgb (macro on) or 0 (macro off).
- random is delayed one stage so it stays aligned with the pixel.
- Overlay FSM, two states:
  - IDLE → OVERLAY on overlay_start. Latch ovl_rgb = game_won ? WIN_RGB : LOSE_RGB and load cnt = OVERLAY_CYCLES-1.
  - OVERLAY: cnt decrements every cycle. At cnt==0 go to IDLE.
  - cnt width is $clog2(OVERLAY_CYCLES+1); it never wraps.
- overlay_start while in OVERLAY is ignored: no restart, no re-latch of game_won.
- overlay_active is a registered FSM output; it is high for exactly OVERLAY_CYCLES cycles.

## Timing
- Pixel latency is 2 cycles, inputs to rgb/hit/hit_layer. Fully pipelined: one pixel per cycle, no stalls.
- Overlay start timing:
  - overlay_start in cycle t → overlay_active high from t+1 through t+OVERLAY_CYCLES.
  - The stage-2 register samples FSM state, so rgb shows overlay colour from t+2 through t+OVERLAY_CYCLES+1.
- Reset values: rgb=0, hit=0, hit_layer=0, overlay_active=0, FSM=IDLE, cnt=0, pipeline registers=0.
- Reset mid-overlay aborts the overlay immediately (asynchronous clear).
- All layers masked or none enabled → hit=0, hit_layer=0, rgb=background.
- Multiple layers enabled → only the lowest index is reported; the others are ignored.

## Configuration
- GAME_LAYER_MIXER_BG_EN defined: empty pixels output bg_rgb, sampled in the same pipeline stage as the layers (2-cycle latency).
- Not defined: bg_rgb is unused, and empty pixels output all-zero.

## Test plan
- Priority: eff bits 3 and 7 set, layer3=3'b010, layer7=3'b101 → after 2 cycles rgb=3'b010, hit=1, hit_layer=3.
- Mask: same stimulus with layer_mask[3]=0 → rgb=3'b101, hit_layer=7; all masked → hit=0, rgb=0 (or bg_rgb=3'b001 with macro).
- Overlay: OVERLAY_CYCLES=4, overlay_start with game_won=1, random=0 → overlay_active high exactly 4 cycles, rgb=3'b100 during the overlay window, then layer colour again.
- Overlay noise and ignored restart: game_won=0, random=1 → rgb=3'b111; a second overlay_start pulse during the overlay does not extend it.
- Reset: assert rst asynchronously mid-overlay and mid-pixel-stream → all outputs 0 within the same cycle; FSM back in IDLE after release.
- Throughput: random eff/rgb every cycle against a reference model delayed 2 cycles; N_LAYERS=2 and N_LAYERS=32 builds both pass.
